glitch_cmd_ctrl: RTL and testbench

//  Command sequencer behind the UART receiver: consumes received bytes (ready pulse + byte),

---
 rtl/glitch_pkg.sv | 31 +++
 rtl/glitch_cmd_ctrl_if.sv | 26 ++
 rtl/glitch_cmd_ctrl.sv | 177 +++++++++++++++++
 tb/tb_glitch_cmd_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch command controller.
// Holds the opcode byte values, the parser FSM state encoding and helpers
// that tell how many payload bytes follow an opcode.
package glitch_pkg;

  localparam logic [7:0] OP_DELAY  = 8'h64;  // 'd' + 4 payload bytes
  localparam logic [7:0] OP_WIDTH  = 8'h77;  // 'w' + 2 payload bytes
  localparam logic [7:0] OP_ARM    = 8'h61;  // 'a'
  localparam logic [7:0] OP_DISARM = 8'h72;  // 'r'

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_EXEC,
    ST_RESP
  } state_t;

  // Number of payload bytes that follow an opcode; 0 for opcode-only or unknown.
  function automatic logic [2:0] payload_len(input logic [7:0] op);
    case (op)
      OP_DELAY: return 3'd4;
      OP_WIDTH: return 3'd2;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    return (op == OP_ARM) || (op == OP_DISARM) || (payload_len(op) != 3'd0);
  endfunction

endpackage

// File: rtl/glitch_cmd_ctrl_if.sv
// UART-side handshake bundle of the glitch command controller.
//   i_rx_ready  receiver -> ctrl : one-cycle pulse, i_rx_byte valid
//   i_rx_byte   receiver -> ctrl : received byte
//   i_tx_busy   transmitter -> ctrl : transmitter busy
//   o_tx_start  ctrl -> transmitter : one-cycle pulse, send o_tx_byte
//   o_tx_byte   ctrl -> transmitter : response byte
// master = UART side, slave = controller.
interface glitch_cmd_ctrl_if;

  logic       i_rx_ready;
  logic [7:0] i_rx_byte;
  logic       i_tx_busy;
  logic       o_tx_start;
  logic [7:0] o_tx_byte;

  modport master (
    output i_rx_ready, i_rx_byte, i_tx_busy,
    input  o_tx_start, o_tx_byte
  );

  modport slave (
    input  i_rx_ready, i_rx_byte, i_tx_busy,
    output o_tx_start, o_tx_byte
  );

endinterface

// File: rtl/glitch_cmd_ctrl.sv
// Command sequencer between uart_rx/uart_tx and the glitch pulse generator.
// Parses framed opcode+payload commands from the receiver, configures the
// glitch engine (delay, width, arm) and answers every frame with ACK or NAK.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   uart        UART handshake bundle (slave modport)
//   i_fired     one-cycle pulse: armed glitch has fired
//   o_delay     glitch delay in clk cycles
//   o_width     glitch width in clk cycles (never 0)
//   o_armed     glitch engine armed
//   o_overrun   one-cycle pulse: byte dropped while a response was pending
module glitch_cmd_ctrl
  import glitch_pkg::*;
#(
  parameter int         CLK_FREQ       = 12000000,
  parameter int         TIMEOUT_CYCLES = CLK_FREQ / 100,
  parameter logic [7:0] ACK_BYTE       = 8'h6B,
  parameter logic [7:0] NAK_BYTE       = 8'h3F
) (
  input  logic                     clk,
  input  logic                     rst_n,
  glitch_cmd_ctrl_if.slave         uart,
  input  logic                     i_fired,
  output logic [31:0]              o_delay,
  output logic [15:0]              o_width,
  output logic                     o_armed,
  output logic                     o_overrun
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES);

  logic       rx_ready;
  logic [7:0] rx_byte;
  logic       tx_busy;
  assign rx_ready = uart.i_rx_ready;
  assign rx_byte  = uart.i_rx_byte;
  assign tx_busy  = uart.i_tx_busy;

  state_t             state, state_next;
  logic [7:0]         opcode;
  logic [2:0]         count;
  logic [31:0]        shadow;
  logic [GAP_W-1:0]   gap;
  logic               gap_expired;
  logic               tx_start_q;
  logic [7:0]         tx_byte_q;

  logic               load_resp;
  logic [7:0]         resp_byte;
  logic               commit_delay;
  logic               commit_width;
  logic               set_arm;
  logic               clr_arm;
  logic               send;

  assign gap_expired   = (gap == GAP_W'(TIMEOUT_CYCLES - 1));
  assign uart.o_tx_start = tx_start_q;
  assign uart.o_tx_byte  = tx_byte_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic. A byte arriving on the same cycle the gap timer
  // expires still counts, so the frame is not aborted.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rx_ready) begin
          if (payload_len(rx_byte) != 3'd0) state_next = ST_PAYLOAD;
          else if (is_known(rx_byte))       state_next = ST_EXEC;
          else                              state_next = ST_RESP;
        end
      end
      ST_PAYLOAD: begin
        if (rx_ready) begin
          if (count == 3'd1) state_next = ST_EXEC;
        end else if (gap_expired) begin
          state_next = ST_RESP;
        end
      end
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (!tx_busy) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: response selection and commit strobes.
  always_comb begin
    load_resp    = 1'b0;
    resp_byte    = NAK_BYTE;
    commit_delay = 1'b0;
    commit_width = 1'b0;
    set_arm      = 1'b0;
    clr_arm      = 1'b0;
    send         = 1'b0;
    case (state)
      ST_IDLE:    load_resp = rx_ready && !is_known(rx_byte);
      ST_PAYLOAD: load_resp = !rx_ready && gap_expired;
      ST_EXEC: begin
        load_resp = 1'b1;
        case (opcode)
          OP_DELAY: begin
            if (!o_armed) begin
              commit_delay = 1'b1;
              resp_byte    = ACK_BYTE;
            end
          end
          OP_WIDTH: begin
            // A zero width would make the engine emit nothing; refuse it.
            if (!o_armed && shadow[15:0] != 16'd0) begin
              commit_width = 1'b1;
              resp_byte    = ACK_BYTE;
            end
          end
          OP_ARM: begin
            set_arm   = 1'b1;
            resp_byte = ACK_BYTE;
          end
          OP_DISARM: begin
            clr_arm   = 1'b1;
            resp_byte = ACK_BYTE;
          end
          default: resp_byte = NAK_BYTE;
        endcase
      end
      ST_RESP: send = !tx_busy;
      default: ;
    endcase
  end

  // Frame capture: opcode, remaining byte count, payload shadow and gap timer.
  // The shadow is cleared per frame so a short payload never carries old bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode <= 8'h00;
      count  <= 3'd0;
      shadow <= 32'd0;
      gap    <= '0;
    end else begin
      if (state == ST_IDLE && rx_ready) begin
        opcode <= rx_byte;
        count  <= payload_len(rx_byte);
        shadow <= 32'd0;
      end else if (state == ST_PAYLOAD && rx_ready) begin
        shadow <= {shadow[23:0], rx_byte};
        count  <= count - 3'd1;
      end
      if (state == ST_PAYLOAD && !rx_ready) gap <= gap + 1'b1;
      else                                  gap <= '0;
    end
  end

  // Registered outputs. Arm commit has priority over a simultaneous fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_delay    <= 32'd0;
      o_width    <= 16'd1;
      o_armed    <= 1'b0;
      o_overrun  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      if (commit_delay) o_delay <= shadow;
      if (commit_width) o_width <= shadow[15:0];
      if (set_arm)                 o_armed <= 1'b1;
      else if (clr_arm || i_fired) o_armed <= 1'b0;
      if (load_resp) tx_byte_q <= resp_byte;
      tx_start_q <= send;
      o_overrun  <= rx_ready && (state == ST_EXEC || state == ST_RESP);
    end
  end

endmodule

// File: tb/tb_glitch_cmd_ctrl.sv
// Testbench for glitch_cmd_ctrl: directed command frames, responses checked
// against a queue of expected ACK/NAK bytes.
module tb_glitch_cmd_ctrl;

  localparam int         TIMEOUT = 16;
  localparam logic [7:0] ACK = 8'h6B;
  localparam logic [7:0] NAK = 8'h3F;

  logic        clk;
  logic        rst_n;
  logic        fired;
  logic [31:0] delay;
  logic [15:0] width;
  logic        armed;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int tx_count = 0;
  int tx_expect = 0;
  int ovr_count = 0;
  logic [7:0] exp_q[$];

  glitch_cmd_ctrl_if bus();

  glitch_cmd_ctrl #(
    .CLK_FREQ(12000000),
    .TIMEOUT_CYCLES(TIMEOUT),
    .ACK_BYTE(ACK),
    .NAK_BYTE(NAK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart(bus),
    .i_fired(fired),
    .o_delay(delay),
    .o_width(width),
    .o_armed(armed),
    .o_overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every tx_start pops the scoreboard.
  always @(negedge clk) begin
    if (bus.o_tx_start === 1'b1) begin
      tx_count++;
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("[TB] FAIL unexpected_tx: observed byte %0h expected no response", bus.o_tx_byte);
      end
      if (exp_q.size() != 0) check("tx_byte", {24'd0, bus.o_tx_byte}, {24'd0, exp_q.pop_front()});
    end
    if (overrun === 1'b1) ovr_count++;
  end

  task automatic expect_resp(input logic [7:0] b);
    exp_q.push_back(b);
    tx_expect++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_byte  = b;
    bus.i_rx_ready = 1'b1;
    @(negedge clk);
    bus.i_rx_ready = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    int cycles = 0;
    while (tx_count < tx_expect && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    @(negedge clk);
    check(tag, tx_count, tx_expect);
  endtask

  initial begin
    rst_n = 1'b0;
    fired = 1'b0;
    bus.i_rx_ready = 1'b0;
    bus.i_rx_byte  = 8'h00;
    bus.i_tx_busy  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_delay", delay, 32'd0);
    check("reset_width", {16'd0, width}, 32'd1);
    check("reset_armed", {31'd0, armed}, 32'd0);
    check("reset_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
    check("reset_tx_byte", {24'd0, bus.o_tx_byte}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Delay command with exact latency checks.
    expect_resp(ACK);
    send_byte(8'h64); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    check("delay_partial", delay, 32'd0);
    send_byte(8'h2C);
    check("delay_before_commit", delay, 32'd0);
    @(negedge clk);
    check("delay_committed", delay, 32'd300);
    check("tx_start_not_early", {31'd0, bus.o_tx_start}, 32'd0);
    wait_tx("delay_resp_count");

    // Zero width is refused.
    expect_resp(NAK);
    send_byte(8'h77); send_byte(8'h00); send_byte(8'h00);
    wait_tx("width0_resp_count");
    check("width0_unchanged", {16'd0, width}, 32'd1);

    // Valid width.
    expect_resp(ACK);
    send_byte(8'h77); send_byte(8'h00); send_byte(8'h10);
    wait_tx("width_resp_count");
    check("width_16", {16'd0, width}, 32'd16);

    // Unknown opcode.
    expect_resp(NAK);
    send_byte(8'h78);
    wait_tx("unknown_resp_count");
    check("unknown_delay", delay, 32'd300);
    check("unknown_width", {16'd0, width}, 32'd16);

    // Truncated frame times out.
    send_byte(8'h64); send_byte(8'h12); send_byte(8'h34);
    repeat (TIMEOUT - 6) @(negedge clk);
    check("no_early_abort", tx_count, tx_expect);
    expect_resp(NAK);
    wait_tx("timeout_resp_count");
    check("timeout_delay", delay, 32'd300);

    // Arm, then refused config while armed.
    expect_resp(ACK);
    send_byte(8'h61);
    wait_tx("arm_resp_count");
    check("armed_set", {31'd0, armed}, 32'd1);
    expect_resp(NAK);
    send_byte(8'h77); send_byte(8'h00); send_byte(8'h20);
    wait_tx("armed_width_resp_count");
    check("armed_width_unchanged", {16'd0, width}, 32'd16);
    expect_resp(NAK);
    send_byte(8'h64); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    wait_tx("armed_delay_resp_count");
    check("armed_delay_unchanged", delay, 32'd300);
    expect_resp(ACK);
    send_byte(8'h61);
    wait_tx("rearm_resp_count");
    check("rearm_stays", {31'd0, armed}, 32'd1);

    // Fire pulse disarms.
    fired = 1'b1;
    @(negedge clk);
    fired = 1'b0;
    check("fired_disarm", {31'd0, armed}, 32'd0);

    // Disarm while not armed still ACKs.
    expect_resp(ACK);
    send_byte(8'h72);
    wait_tx("disarm_resp_count");
    check("disarm_idle", {31'd0, armed}, 32'd0);

    // Fire in the same cycle as the arm commit: arm wins.
    expect_resp(ACK);
    send_byte(8'h61);
    fired = 1'b1;
    @(negedge clk);
    fired = 1'b0;
    check("arm_beats_fire", {31'd0, armed}, 32'd1);
    wait_tx("arm_fire_resp_count");

    // Transmitter busy in RESP, extra byte dropped as overrun.
    bus.i_tx_busy = 1'b1;
    expect_resp(ACK);
    send_byte(8'h72);
    repeat (5) @(negedge clk);
    send_byte(8'h78);
    check("overrun_pulse", {31'd0, overrun}, 32'd1);
    repeat (44) @(negedge clk);
    check("busy_holds_tx", tx_count, tx_expect - 1);
    check("overrun_count", ovr_count, 32'd1);
    bus.i_tx_busy = 1'b0;
    wait_tx("busy_resp_count");
    check("busy_disarmed", {31'd0, armed}, 32'd0);

    // Reset in the middle of a frame.
    expect_resp(ACK);
    send_byte(8'h61);
    wait_tx("pre_reset_arm_count");
    send_byte(8'h64); send_byte(8'hAA); send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    check("midreset_delay", delay, 32'd0);
    check("midreset_width", {16'd0, width}, 32'd1);
    check("midreset_armed", {31'd0, armed}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_resp(ACK);
    send_byte(8'h64); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    wait_tx("post_reset_resp_count");
    check("post_reset_delay", delay, 32'd5);

    repeat (20) @(negedge clk);
    check("final_tx_count", tx_count, tx_expect);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
